// File: rtl/jacobi_mem_ctrl.sv
// Dual-port RAM sequencer for a Jacobi eigen-solver: streams the matrix in and out,
// fetches column pairs (p,q) row by row and writes the rotated columns back.
//
// state        | meaning
// S_IDLE       | waiting for start_load / cmd_valid / start_unload
// S_LOAD       | accepting N*N row-major beats on the load stream
// S_FETCH      | reading (k,p) and (k,q) for k = 0..N-1, one row per cycle
// S_WRBACK     | writing N rotated (k,p)/(k,q) pairs back
// S_UNLOAD_RD  | issuing the read for the next unload beat
// S_UNLOAD_OUT | presenting the unload beat until the sink takes it
module jacobi_mem_ctrl #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_load,
  input  logic                  start_unload,
  input  logic                  cmd_valid,
  input  logic [ADDR_WIDTH-1:0] cmd_p,
  input  logic [ADDR_WIDTH-1:0] cmd_q,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  pair_valid,
  output logic [DATA_WIDTH-1:0] pair_a,
  output logic [DATA_WIDTH-1:0] pair_b,
  output logic [ADDR_WIDTH-1:0] pair_idx,
  input  logic                  wb_valid,
  input  logic [DATA_WIDTH-1:0] wb_a,
  input  logic [DATA_WIDTH-1:0] wb_b,
  output logic                  wb_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  ram_en_a,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  input  logic [DATA_WIDTH-1:0] ram_dout_a,
  output logic                  ram_en_b,
  output logic                  ram_we_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_din_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD       = 3'd1;
  localparam logic [2:0] S_FETCH      = 3'd2;
  localparam logic [2:0] S_WRBACK     = 3'd3;
  localparam logic [2:0] S_UNLOAD_RD  = 3'd4;
  localparam logic [2:0] S_UNLOAD_OUT = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] DIM      = ADDR_WIDTH'(N);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_EL  = ADDR_WIDTH'(N * N - 1);

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] p_q;
  logic [ADDR_WIDTH-1:0] q_q;
  logic                  pair_valid_q;
  logic [ADDR_WIDTH-1:0] pair_idx_q;
  logic                  done_q;
  logic                  err_q;
  logic                  cmd_bad;

  assign cmd_bad = (cmd_p == cmd_q) || (cmd_p >= DIM) || (cmd_q >= DIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      row_base     <= '0;
      p_q          <= '0;
      q_q          <= '0;
      pair_valid_q <= 1'b0;
      pair_idx_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      pair_valid_q <= 1'b0;
      pair_idx_q   <= '0;
      case (state)
        S_IDLE: begin
          if (start_load) begin
            state    <= S_LOAD;
            cnt      <= '0;
            row_base <= '0;
          end else if (cmd_valid) begin
            if (cmd_bad) begin
              err_q <= 1'b1;
            end else begin
              p_q      <= cmd_p;
              q_q      <= cmd_q;
              cnt      <= '0;
              row_base <= '0;
              state    <= S_FETCH;
            end
          end else if (start_unload) begin
            state    <= S_UNLOAD_RD;
            cnt      <= '0;
            row_base <= '0;
          end
        end
        S_LOAD: begin
          if (s_valid) begin
            if (cnt == LAST_EL) begin
              state  <= S_IDLE;
              cnt    <= '0;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_FETCH: begin
          // RAM data for row cnt lands next cycle, so the pair flag is delayed to match
          pair_valid_q <= 1'b1;
          pair_idx_q   <= cnt;
          if (cnt == LAST_ROW) begin
            state    <= S_WRBACK;
            cnt      <= '0;
            row_base <= '0;
          end else begin
            cnt      <= cnt + 1'b1;
            row_base <= row_base + DIM;
          end
        end
        S_WRBACK: begin
          if (wb_valid) begin
            if (cnt == LAST_ROW) begin
              state    <= S_IDLE;
              cnt      <= '0;
              row_base <= '0;
              done_q   <= 1'b1;
            end else begin
              cnt      <= cnt + 1'b1;
              row_base <= row_base + DIM;
            end
          end
        end
        S_UNLOAD_RD: begin
          state <= S_UNLOAD_OUT;
        end
        S_UNLOAD_OUT: begin
          if (m_ready) begin
            if (cnt == LAST_EL) begin
              state  <= S_IDLE;
              cnt    <= '0;
              done_q <= 1'b1;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= S_UNLOAD_RD;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // RAM ports and stream handshakes are pure decode of state and counters
  always_comb begin
    ram_en_a   = 1'b0;
    ram_we_a   = 1'b0;
    ram_addr_a = '0;
    ram_din_a  = '0;
    ram_en_b   = 1'b0;
    ram_we_b   = 1'b0;
    ram_addr_b = '0;
    ram_din_b  = '0;
    s_ready    = 1'b0;
    wb_ready   = 1'b0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_last     = 1'b0;
    case (state)
      S_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          ram_en_a   = 1'b1;
          ram_we_a   = 1'b1;
          ram_addr_a = cnt;
          ram_din_a  = s_data;
        end
      end
      S_FETCH: begin
        ram_en_a   = 1'b1;
        ram_addr_a = row_base + p_q;
        ram_en_b   = 1'b1;
        ram_addr_b = row_base + q_q;
      end
      S_WRBACK: begin
        wb_ready = 1'b1;
        if (wb_valid) begin
          ram_en_a   = 1'b1;
          ram_we_a   = 1'b1;
          ram_addr_a = row_base + p_q;
          ram_din_a  = wb_a;
          ram_en_b   = 1'b1;
          ram_we_b   = 1'b1;
          ram_addr_b = row_base + q_q;
          ram_din_b  = wb_b;
        end
      end
      S_UNLOAD_RD: begin
        ram_en_a   = 1'b1;
        ram_addr_a = cnt;
      end
      S_UNLOAD_OUT: begin
        // port A stays idle here so the RAM output register holds the beat during a stall
        m_valid = 1'b1;
        m_data  = ram_dout_a;
        m_last  = (cnt == LAST_EL);
      end
      default: begin
      end
    endcase
  end

  assign pair_valid = pair_valid_q;
  assign pair_idx   = pair_idx_q;
  assign pair_a     = pair_valid_q ? ram_dout_a : '0;
  assign pair_b     = pair_valid_q ? ram_dout_b : '0;
  assign busy       = (state != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_jacobi_mem_ctrl.sv
// Scoreboard bench for jacobi_mem_ctrl: directed load/fetch/writeback/unload sequences
// against a behavioural dual-port RAM and a bench-side golden copy of the matrix.
module tb_jacobi_mem_ctrl;
  localparam int N  = 8;
  localparam int DW = 20;
  localparam int AW = 7;
  localparam int NN = N * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_load = 1'b0, start_unload = 1'b0, cmd_valid = 1'b0;
  logic [AW-1:0] cmd_p = '0, cmd_q = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          pair_valid;
  logic [DW-1:0] pair_a, pair_b;
  logic [AW-1:0] pair_idx;
  logic          wb_valid = 1'b0;
  logic [DW-1:0] wb_a = '0, wb_b = '0;
  logic          wb_ready, m_valid, m_last;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b1;
  logic          busy, done, err;
  logic          ram_en_a, ram_we_a, ram_en_b, ram_we_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_din_a, ram_din_b;
  logic [DW-1:0] ram_dout_a, ram_dout_b;

  always #5 clk = ~clk;

  jacobi_mem_ctrl #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_load(start_load), .start_unload(start_unload),
    .cmd_valid(cmd_valid), .cmd_p(cmd_p), .cmd_q(cmd_q),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .pair_valid(pair_valid), .pair_a(pair_a), .pair_b(pair_b), .pair_idx(pair_idx),
    .wb_valid(wb_valid), .wb_a(wb_a), .wb_b(wb_b), .wb_ready(wb_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .done(done), .err(err),
    .ram_en_a(ram_en_a), .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a),
    .ram_din_a(ram_din_a), .ram_dout_a(ram_dout_a),
    .ram_en_b(ram_en_b), .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b),
    .ram_din_b(ram_din_b), .ram_dout_b(ram_dout_b)
  );

  // synchronous-read RAM whose output register holds while the port is idle
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_en_a) begin
      if (ram_we_a) ram[ram_addr_a] <= ram_din_a;
      else          ram_dout_a      <= ram[ram_addr_a];
    end
    if (ram_en_b) begin
      if (ram_we_b) ram[ram_addr_b] <= ram_din_b;
      else          ram_dout_b      <= ram[ram_addr_b];
    end
  end

  typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; logic [AW-1:0] idx; } pair_t;
  typedef struct { logic [DW-1:0] data; logic last; } beat_t;
  pair_t pq[$];
  beat_t mq[$];
  int    exp_mem [0:NN-1];
  int    tests = 0;
  int    fails = 0;
  int    pv_run = 0;
  int    pv_last = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctrl"}, 64'({busy, done, err, pair_valid, m_valid, m_last, s_ready, wb_ready,
                               ram_en_a, ram_en_b, ram_we_a, ram_we_b}), 64'(0));
    check({tag, "_addr"}, 64'({ram_addr_a, ram_addr_b, pair_idx}), 64'(0));
    check({tag, "_din"},  64'({ram_din_a, ram_din_b}), 64'(0));
    check({tag, "_pair"}, 64'({pair_a, pair_b}), 64'(0));
    check({tag, "_mdata"}, 64'(m_data), 64'(0));
  endtask

  // monitor: samples after the main thread has driven this cycle's inputs
  initial begin
    logic          hold_v;
    logic [DW-1:0] hold_d;
    pair_t         ep;
    beat_t         eb;
    hold_v = 1'b0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold_v = 1'b0;
        pv_run = 0;
      end else begin
        if (pair_valid) begin
          if (pq.size() == 0) begin
            tests++; fails++;
            $display("FAIL pair_unexpected: got idx %0d expected no pair", pair_idx);
          end else begin
            ep = pq.pop_front();
            check("pair_a", 64'(pair_a), 64'(ep.a));
            check("pair_b", 64'(pair_b), 64'(ep.b));
            check("pair_idx", 64'(pair_idx), 64'(ep.idx));
          end
          pv_run++;
        end else begin
          if (pv_run != 0) pv_last = pv_run;
          pv_run = 0;
        end
        if (hold_v) begin
          check("m_hold_valid", 64'(m_valid), 64'(1));
          check("m_hold_data", 64'(m_data), 64'(hold_d));
        end
        hold_v = m_valid && !m_ready;
        hold_d = m_data;
        if (m_valid && m_ready) begin
          if (mq.size() == 0) begin
            tests++; fails++;
            $display("FAIL m_unexpected: got data %0d expected no beat", m_data);
          end else begin
            eb = mq.pop_front();
            check("m_data", 64'(m_data), 64'(eb.data));
            check("m_last", 64'(m_last), 64'(eb.last));
          end
        end
      end
    end
  end

  task automatic do_load(input int base, input bit toggle, input bit with_cmd);
    int beat = 0;
    int cyc = 0;
    bit v;
    @(negedge clk);
    start_load = 1'b1;
    if (with_cmd) begin cmd_valid = 1'b1; cmd_p = 7'd2; cmd_q = 7'd5; end
    @(negedge clk);
    start_load = 1'b0;
    cmd_valid  = 1'b0;
    check("load_busy", 64'(busy), 64'(1));
    check("load_s_ready", 64'(s_ready), 64'(1));
    while (beat < NN && cyc < 400) begin
      v = toggle ? (cyc % 2 == 0) : 1'b1;
      s_valid   = v;
      s_data    = DW'(base + beat);
      cmd_valid = with_cmd && (cyc % 2 == 1);
      if (v) begin exp_mem[beat] = base + beat; beat++; end
      @(negedge clk);
      cyc++;
    end
    s_valid   = 1'b0;
    cmd_valid = 1'b0;
    check("load_beats", 64'(beat), 64'(NN));
    check("load_done", 64'(done), 64'(1));
    check("load_idle", 64'(busy), 64'(0));
    repeat (12) @(negedge clk);
    check("load_no_fetch", 64'(busy), 64'(0));
  endtask

  task automatic do_unload(input int stall_beat, input int stall_len);
    int    beat = 0;
    int    stalled = 0;
    int    cyc = 0;
    beat_t b;
    for (int i = 0; i < NN; i++) begin
      b.data = DW'(exp_mem[i]);
      b.last = (i == NN - 1);
      mq.push_back(b);
    end
    @(negedge clk);
    start_unload = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    start_unload = 1'b0;
    while (beat < NN && cyc < 1000) begin
      if (m_valid && beat == stall_beat && stalled < stall_len) begin
        m_ready = 1'b0;
        stalled++;
        check("stall_data", 64'(m_data), 64'(exp_mem[beat]));
      end else begin
        m_ready = 1'b1;
        if (m_valid) beat++;
      end
      @(negedge clk);
      cyc++;
    end
    m_ready = 1'b1;
    check("unload_beats", 64'(beat), 64'(NN));
    check("unload_done", 64'(done), 64'(1));
  endtask

  task automatic do_fetch(input int p, input int q, input int nwb, input int va, input int vb);
    int    cyc = 0;
    pair_t e;
    for (int k = 0; k < N; k++) begin
      e.a   = DW'(exp_mem[k*N + p]);
      e.b   = DW'(exp_mem[k*N + q]);
      e.idx = AW'(k);
      pq.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_p = AW'(p);
    cmd_q = AW'(q);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("fetch_busy", 64'(busy), 64'(1));
    while (!wb_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("fetch_to_wrback", 64'(wb_ready), 64'(1));
    for (int j = 0; j < nwb; j++) begin
      wb_valid = 1'b1;
      wb_a = DW'(va + j);
      wb_b = DW'(vb + j);
      exp_mem[j*N + p] = va + j;
      exp_mem[j*N + q] = vb + j;
      @(negedge clk);
    end
    wb_valid = 1'b0;
    if (nwb == N) begin
      check("wb_done", 64'(done), 64'(1));
      check("wb_idle", 64'(busy), 64'(0));
      check("pair_run", 64'(pv_last), 64'(N));
    end else begin
      rst_n = 1'b0;
      #1;
      check_idle("midrst");
      pq.delete();
      @(negedge clk);
      check_idle("midrst_hold");
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_idle", 64'(busy), 64'(0));
    end
  endtask

  task automatic do_err(input int p, input int q);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_p = AW'(p);
    cmd_q = AW'(q);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("err_pulse", 64'(err), 64'(1));
    check("err_busy", 64'(busy), 64'(0));
    check("err_ram", 64'({ram_en_a, ram_en_b, ram_we_a, ram_we_b}), 64'(0));
    @(negedge clk);
    check("err_clear", 64'(err), 64'(0));
    check("err_still_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    do_load(0, 1'b1, 1'b0);
    do_unload(-1, 0);
    do_err(3, 3);
    do_err(9, 1);
    do_unload(10, 5);
    do_fetch(2, 5, N, 100, 200);
    do_unload(-1, 0);
    do_fetch(1, 6, 3, 700, 800);
    do_unload(-1, 0);
    do_load(500, 1'b0, 1'b1);
    do_unload(-1, 0);
    repeat (3) @(negedge clk);
    check("pair_q_empty", 64'(pq.size()), 64'(0));
    check("m_q_empty", 64'(mq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jacobi_mem_ctrl.md
JACOBI_MEM_CTRL -- requirements
Module: jacobi_mem_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- N, 8, matrix dimension
- DATA_WIDTH, 20, element width
- ADDR_WIDTH, 7, RAM address width; N*N <= 2**ADDR_WIDTH
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock
- rst_n, in, 1, asynchronous active-low reset
- start_load, in, 1, request matrix load
- start_unload, in, 1, request matrix unload
- cmd_valid, in, 1, column-pair fetch request
- cmd_p, in, ADDR_WIDTH, column p
- cmd_q, in, ADDR_WIDTH, column q
- s_valid, in, 1, load beat valid
- s_data, in, DATA_WIDTH, load data
- s_ready, out, 1, load beat accepted
- pair_valid, out, 1, fetched pair valid
- pair_a, out, DATA_WIDTH, element (k,p)
- pair_b, out, DATA_WIDTH, element (k,q)
- pair_idx, out, ADDR_WIDTH, row k
- wb_valid, in, 1, writeback beat valid
- wb_a, in, DATA_WIDTH, new (k,p)
- wb_b, in, DATA_WIDTH, new (k,q)
- wb_ready, out, 1, writeback accepted
- m_valid, out, 1, unload beat valid
- m_data, out, DATA_WIDTH, unload data
- m_last, out, 1, final unload beat
- m_ready, in, 1, unload sink ready
- busy, out, 1, state not IDLE
- done, out, 1, one-cycle operation-complete pulse
- err, out, 1, one-cycle command-rejected pulse
- ram_en_a, out, 1, RAM port A enable
- ram_we_a, out, 1, RAM port A write enable
- ram_addr_a, out, ADDR_WIDTH, RAM port A address
- ram_din_a, out, DATA_WIDTH, RAM port A write data
- ram_dout_a, in, DATA_WIDTH, RAM port A read data
- ram_en_b, out, 1, RAM port B enable
- ram_we_b, out, 1, RAM port B write enable
- ram_addr_b, out, ADDR_WIDTH, RAM port B address
- ram_din_b, out, DATA_WIDTH, RAM port B write data
- ram_dout_b, in, DATA_WIDTH, RAM port B read data

Function
REQ-003 RAM layout SHALL be row-major: element (r,c) at address r*N+c.
REQ-004 RAM port outputs SHALL be combinational from state and counters; RAM read data SHALL be valid one cycle after the enabled read.
REQ-005 States SHALL be IDLE, LOAD, FETCH, WRBACK, UNLOAD_RD and UNLOAD_OUT.
REQ-006 Requests SHALL be sampled only in IDLE; if several are asserted together, priority SHALL be start_load > cmd_valid > start_unload. Requests outside IDLE SHALL be ignored.
REQ-007 cmd_valid with cmd_p == cmd_q, cmd_p >= N or cmd_q >= N SHALL be rejected: err pulses 1 cycle later and the state stays IDLE.
REQ-008 In LOAD, s_ready SHALL be 1. Each s_valid && s_ready beat SHALL drive port A with en=we=1, addr=cnt, din=s_data, then increment cnt. After beat N*N-1, next state SHALL be IDLE and done SHALL pulse in the same cycle that IDLE is entered.
REQ-009 In FETCH, for k = 0..N-1 on consecutive cycles, the block SHALL read port A at k*N+p and port B at k*N+q. One cycle after each read it SHALL assert pair_valid with pair_a=ram_dout_a, pair_b=ram_dout_b and pair_idx=k. pair_valid has no backpressure.
REQ-010 After issuing read k=N-1 the block SHALL enter WRBACK. The final pair_valid SHALL occur in the first WRBACK cycle.
REQ-011 In WRBACK, wb_ready SHALL be 1. Each wb_valid beat j (j = 0..N-1) SHALL write wb_a to j*N+p via port A and wb_b to j*N+q via port B in the same cycle. After beat N-1 the block SHALL enter IDLE and pulse done.
REQ-012 In UNLOAD_RD, port A SHALL read address cnt (en=1, we=0), then the block SHALL move to UNLOAD_OUT. In UNLOAD_OUT:
- m_valid=1, m_data=ram_dout_a, port A disabled;
- m_last=1 when cnt == N*N-1;
- on m_ready, cnt increments and the next state is UNLOAD_RD, or IDLE with a done pulse after the last beat.
Throughput SHALL be 1 beat per 2 cycles maximum.
REQ-013 m_data and m_valid SHALL be held stable while m_valid && !m_ready.
REQ-014 p and q SHALL be latched at command acceptance. Counters SHALL clear on every operation start.
REQ-015 ram_en_*, ram_we_*, s_ready, wb_ready and m_valid SHALL be 0 in states where they are not specified above.

Reset
REQ-016 While rst_n=0, the block SHALL hold:
- state IDLE; all counters 0;
- busy, done, err, pair_valid, m_valid, m_last, s_ready, wb_ready, ram_en_a/b and ram_we_a/b all 0;
- data and address outputs 0.
REQ-017 Reset asserted mid-operation SHALL abort immediately. Writes completed before reset SHALL remain in RAM; there is no partial-write rollback.

Verification
REQ-018 The bench SHALL cover these scenarios (stimulus -> required response):
- N=8 load of values 0..63 with s_valid toggled every other cycle, then unload with m_ready=1 -> 64 beats in order 0..63, m_last only on 63, done pulses after load and after unload.
- Fetch p=2, q=5 -> pair_valid for 8 consecutive cycles, beat k gives pair_a=8k+2, pair_b=8k+5; writeback wb_a=100+k, wb_b=200+k, then unload -> addresses 8k+2/8k+5 hold 100+k/200+k, all others unchanged.
- cmd_valid with p=q=3, then with p=9 -> err pulses each time, busy stays 0, RAM untouched.
- start_load and cmd_valid asserted in the same IDLE cycle -> LOAD entered, fetch ignored; cmd_valid during LOAD ignored.
- Unload with m_ready held low 5 cycles on beat 10 -> m_data=10 stable throughout; beat 11 follows after m_ready.
- rst_n pulsed low during WRBACK after 3 beats -> outputs at reset values, rows 0..2 updated, rows 3..7 hold old values.
